// File: rtl/cache_pkg.sv
// Cache-side shared definitions: arbiter states and the dcache burst counter helper.
package cache_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_DSERVE = 2'd1,
        ARB_ISERVE = 2'd2
    } arb_state_t;

    localparam int DBURST_W = 8;

    // Saturating increment so a very long dcache run cannot wrap back to zero.
    function automatic logic [DBURST_W-1:0] sat_inc(input logic [DBURST_W-1:0] v);
        return (&v) ? v : v + DBURST_W'(1);
    endfunction

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the RAM word and the RAM handshake state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter_perf.sv
// Grant/conflict event counters for mem_arbiter; 32-bit, wrapping, cleared by RST.
module mem_arbiter_perf
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  d_done,
    input  logic  i_done,
    input  logic  conflict,
    output word_t dgrant_cnt,
    output word_t igrant_cnt,
    output word_t conflict_cnt
);

    logic [2:0] evt;

    assign evt = {conflict, i_done, d_done};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            word_t cnt_reg;
            always_ff @(posedge CLK) begin
                if (RST) begin
                    cnt_reg <= '0;
                end else if (evt[gi]) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    endgenerate

    assign dgrant_cnt   = g_cnt[0].cnt_reg;
    assign igrant_cnt   = g_cnt[1].cnt_reg;
    assign conflict_cnt = g_cnt[2].cnt_reg;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache onto the single-ported RAM, dcache first with a burst guard.
// Optional counters are built only when MEMARB_PERF_EN is defined.
module mem_arbiter
    import cpu_types_pkg::*;
    import cache_pkg::*;
#(
    parameter int MAX_DBURST = 4
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
`ifdef MEMARB_PERF_EN
    ,
    output word_t     dgrant_cnt,
    output word_t     igrant_cnt,
    output word_t     conflict_cnt
`endif
);

    arb_state_t          state_reg;
    logic [DBURST_W-1:0] dburst_reg;
    logic [DBURST_W:0]   dburst_sum;
    logic                dreq;
    logic                access;
    logic                d_done;
    logic                i_done;
    logic                guard_hit;

    assign dreq       = dREN | dWEN;
    assign access     = (ramstate == ACCESS);
    assign d_done     = (state_reg == ARB_DSERVE) & dreq & access;
    assign i_done     = (state_reg == ARB_ISERVE) & iREN & access;
    assign dburst_sum = {1'b0, dburst_reg} + (DBURST_W + 1)'(1);
    assign guard_hit  = int'(dburst_sum) >= MAX_DBURST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= ARB_IDLE;
            dburst_reg <= '0;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    dburst_reg <= '0;
                    if (dreq)      state_reg <= ARB_DSERVE;
                    else if (iREN) state_reg <= ARB_ISERVE;
                end
                ARB_DSERVE: begin
                    if (!dreq) begin
                        state_reg <= ARB_IDLE;
                    end else if (access) begin
                        // Hand the RAM to a waiting icache once the dcache has had its run.
                        if (iREN && guard_hit) begin
                            state_reg  <= ARB_ISERVE;
                            dburst_reg <= '0;
                        end else begin
                            dburst_reg <= sat_inc(dburst_reg);
                        end
                    end
                end
                ARB_ISERVE: begin
                    if (!iREN) begin
                        state_reg <= ARB_IDLE;
                    end else if (access) begin
                        dburst_reg <= '0;
                        if (dreq) state_reg <= ARB_DSERVE;
                    end
                end
                default: begin
                    state_reg  <= ARB_IDLE;
                    dburst_reg <= '0;
                end
            endcase
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        dwait    = 1'b1;
        iwait    = 1'b1;
        dload    = '0;
        iload    = '0;
        case (state_reg)
            ARB_DSERVE: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~d_done;
                dload    = ramload;
            end
            ARB_ISERVE: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iwait   = ~i_done;
                iload   = ramload;
            end
            default: ;
        endcase
    end

`ifdef MEMARB_PERF_EN
    logic conflict;

    assign conflict = ((state_reg == ARB_DSERVE) & iREN) | ((state_reg == ARB_ISERVE) & dreq);

    mem_arbiter_perf u_perf (
        .CLK          (CLK),
        .RST          (RST),
        .d_done       (d_done),
        .i_done       (i_done),
        .conflict     (conflict),
        .dgrant_cnt   (dgrant_cnt),
        .igrant_cnt   (igrant_cnt),
        .conflict_cnt (conflict_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-side expected-completion queues plus an owner-order queue.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int MAXB = 4;

    logic      CLK = 1'b0;
    logic      RST;
    logic      dREN, dWEN, iREN;
    word_t     daddr, dstore, iaddr;
    logic      dwait, iwait, ramREN, ramWEN;
    word_t     dload, iload, ramaddr, ramstore, ramload;
    ramstate_t ramstate;
`ifdef MEMARB_PERF_EN
    word_t     dgrant_cnt, igrant_cnt, conflict_cnt;
    int        conflict_obs = 0;
`endif

    always #5 CLK = ~CLK;

    mem_arbiter #(.MAX_DBURST(MAXB)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
`ifdef MEMARB_PERF_EN
        ,
        .dgrant_cnt   (dgrant_cnt),
        .igrant_cnt   (igrant_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } xact_t;

    xact_t       dq[$];
    xact_t       iq[$];
    xact_t       de, ie;
    logic [1:0]  exp_owner[$];   // expected {dwait,iwait} at each completion
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          d_prev_cyc = 0, d_last_cyc = 0;

    // RAM model: fixed latency, write-back at ACCESS, unwritten words read a pattern.
    int          ram_lat;
    int          lat_cnt = 0;
    logic        err_inj;
    logic        preload_en;
    logic [31:0] preload_addr, preload_data;
    logic [31:0] ram_mem [4096];
    bit          ram_wr  [4096];
    logic [11:0] ridx;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    assign ridx = ramaddr[13:2];

    always_comb begin
        if (err_inj)                 ramstate = ERROR;
        else if (!(ramREN | ramWEN)) ramstate = FREE;
        else if (lat_cnt >= ram_lat) ramstate = ACCESS;
        else                         ramstate = BUSY;
        ramload = ram_wr[ridx] ? ram_mem[ridx] : pat(ramaddr);
    end

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RST || !(ramREN | ramWEN) || ramstate == ACCESS) lat_cnt <= 0;
        else                                                 lat_cnt <= lat_cnt + 1;
        if (preload_en) begin
            ram_mem[preload_addr[13:2]] <= preload_data;
            ram_wr[preload_addr[13:2]]  <= 1'b1;
        end else if (ramWEN && ramstate == ACCESS) begin
            ram_mem[ridx] <= ramstore;
            ram_wr[ridx]  <= 1'b1;
        end
    end

    // Completion monitor
    always @(negedge CLK) begin
        if (RST) begin
`ifdef MEMARB_PERF_EN
            conflict_obs = 0;
`endif
        end else begin
            if (!dwait) begin
                check_val("d_expected", 32'(dq.size() > 0), 32'd1);
                if (dq.size() > 0) begin
                    de = dq.pop_front();
                    check_val("d_addr", ramaddr, de.addr);
                    check_val("d_wen", 32'(ramWEN), 32'(de.we));
                    check_val("d_ren", 32'(ramREN), 32'(!de.we));
                    if (!de.we) check_val("d_load", dload, de.data);
                end
                check_val("d_iwait_excl", 32'(iwait), 32'd1);
                d_prev_cyc = d_last_cyc;
                d_last_cyc = cyc;
            end
            if (!iwait) begin
                check_val("i_expected", 32'(iq.size() > 0), 32'd1);
                if (iq.size() > 0) begin
                    ie = iq.pop_front();
                    check_val("i_addr", ramaddr, ie.addr);
                    check_val("i_ren", 32'(ramREN), 32'd1);
                    check_val("i_load", iload, ie.data);
                end
            end
            if ((!dwait || !iwait) && exp_owner.size() > 0)
                check_val("owner_order", 32'({dwait, iwait}), 32'(exp_owner.pop_front()));
`ifdef MEMARB_PERF_EN
            if (iREN && (dREN || dWEN) && (ramREN || ramWEN)) conflict_obs = conflict_obs + 1;
`endif
        end
    end

    task automatic d_xfer(input logic [31:0] addr, input logic ren, input logic wen,
                          input logic [31:0] wdata, input logic [31:0] rexp,
                          input bit drop, output int lat);
        xact_t x;
        @(posedge CLK); #1;
        dREN = ren; dWEN = wen; daddr = addr; dstore = wdata;
        x.addr = addr; x.we = wen; x.data = rexp;
        dq.push_back(x);
        lat = 0;
        forever begin
            @(negedge CLK);
            lat++;
            if (!dwait) break;
            if (lat >= 200) begin
                check_val("d_timeout", 32'(lat), 32'd0);
                break;
            end
        end
        if (drop) begin
            @(posedge CLK); #1;
            dREN = 1'b0; dWEN = 1'b0;
        end
    endtask

    task automatic i_xfer(input logic [31:0] addr, input logic [31:0] rexp,
                          input bit drop, output int lat);
        xact_t x;
        @(posedge CLK); #1;
        iREN = 1'b1; iaddr = addr;
        x.addr = addr; x.we = 1'b0; x.data = rexp;
        iq.push_back(x);
        lat = 0;
        forever begin
            @(negedge CLK);
            lat++;
            if (!iwait) break;
            if (lat >= 200) begin
                check_val("i_timeout", 32'(lat), 32'd0);
                break;
            end
        end
        if (drop) begin
            @(posedge CLK); #1;
            iREN = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_a, lat_b, lat_d, lat_i;
        RST = 1'b1; dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0;
        daddr = '0; dstore = '0; iaddr = '0;
        ram_lat = 0; err_inj = 1'b0; preload_en = 1'b0;
        preload_addr = '0; preload_data = '0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // Reset state
        @(negedge CLK);
        check_val("rst_ramREN", 32'(ramREN), 32'd0);
        check_val("rst_ramWEN", 32'(ramWEN), 32'd0);
        check_val("rst_ramaddr", ramaddr, 32'd0);
        check_val("rst_ramstore", ramstore, 32'd0);
        check_val("rst_dwait", 32'(dwait), 32'd1);
        check_val("rst_iwait", 32'(iwait), 32'd1);
        check_val("rst_dload", dload, 32'd0);
        check_val("rst_iload", iload, 32'd0);
`ifdef MEMARB_PERF_EN
        check_val("rst_dgrant", dgrant_cnt, 32'd0);
        check_val("rst_igrant", igrant_cnt, 32'd0);
        check_val("rst_conflict", conflict_cnt, 32'd0);
`endif

        // dcache read, 2 BUSY cycles: completion in cycle 4
        @(posedge CLK); #1;
        preload_en = 1'b1; preload_addr = 32'h40; preload_data = 32'hDEADBEEF;
        @(posedge CLK); #1;
        preload_en = 1'b0;
        ram_lat = 2;
        d_xfer(32'h40, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 1'b1, lat_a);
        check_val("s1_dlat", 32'(lat_a), 32'd4);

        // Simultaneous write and fetch of the same word: write first, fetch sees it
        ram_lat = 1;
        exp_owner.push_back(2'b01);
        exp_owner.push_back(2'b10);
        fork
            d_xfer(32'h80, 1'b0, 1'b1, 32'h11, 32'h0, 1'b1, lat_d);
            i_xfer(32'h80, 32'h11, 1'b1, lat_i);
        join
        check_val("s2_dlat", 32'(lat_d), 32'd3);
        check_val("s2_ilat", 32'(lat_i), 32'd7);

        // dREN and dWEN together: write wins, then read it back on 0-wait RAM
        ram_lat = 0;
        d_xfer(32'h84, 1'b1, 1'b1, 32'h22, 32'h0, 1'b1, lat_a);
        d_xfer(32'h84, 1'b1, 1'b0, 32'h0, 32'h22, 1'b1, lat_a);
        check_val("s3_dlat0", 32'(lat_a), 32'd2);

        // icache alone, 1 BUSY cycle
        ram_lat = 1;
        i_xfer(32'h300, pat(32'h300), 1'b1, lat_i);
        check_val("s4_ilat", 32'(lat_i), 32'd3);

        // Two-word dcache burst with no bubble
        ram_lat = 0;
        d_xfer(32'h3100, 1'b1, 1'b0, 32'h0, pat(32'h3100), 1'b0, lat_a);
        d_xfer(32'h3104, 1'b1, 1'b0, 32'h0, pat(32'h3104), 1'b1, lat_b);
        check_val("s5_lat_first", 32'(lat_a), 32'd2);
        check_val("s5_lat_second", 32'(lat_b), 32'd1);
        check_val("s5_gap", 32'(d_last_cyc - d_prev_cyc), 32'd1);

        // Starvation guard: four dcache words, one fetch, then dcache resumes
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        for (int k = 0; k < MAXB; k++) exp_owner.push_back(2'b01);
        exp_owner.push_back(2'b10);
        exp_owner.push_back(2'b01);
        exp_owner.push_back(2'b01);
        fork
            begin
                int lat_s;
                for (int k = 0; k < 6; k++)
                    d_xfer(32'h100 + 32'(4 * k), 1'b1, 1'b0, 32'h0, pat(32'h100 + 32'(4 * k)),
                           k == 5, lat_s);
            end
            begin
                int lat_f;
                i_xfer(32'h204, pat(32'h204), 1'b1, lat_f);
                check_val("s6_ilat", 32'(lat_f), 32'd6);
`ifdef MEMARB_PERF_EN
                @(negedge CLK);
                check_val("perf_dgrant", dgrant_cnt, 32'd4);
                check_val("perf_igrant", igrant_cnt, 32'd1);
                check_val("perf_conflict", conflict_cnt, 32'(conflict_obs));
`endif
            end
        join
        check_val("s6_order_left", 32'(exp_owner.size()), 32'd0);

        // ERROR for three serve cycles keeps dwait high
        ram_lat = 0;
        err_inj = 1'b1;
        fork
            d_xfer(32'h48, 1'b1, 1'b0, 32'h0, pat(32'h48), 1'b1, lat_a);
            begin
                @(posedge CLK); #1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge CLK);
                    check_val("s7_err_dwait", 32'(dwait), 32'd1);
                end
                @(posedge CLK); #1;
                err_inj = 1'b0;
            end
        join
        check_val("s7_dlat", 32'(lat_a), 32'd5);

        // Reset while a dcache read is stalled
        ram_lat = 20;
        @(posedge CLK); #1;
        dREN = 1'b1; daddr = 32'h44;
        @(negedge CLK);
        @(negedge CLK);
        check_val("s8_pre_ramREN", 32'(ramREN), 32'd1);
        check_val("s8_pre_dwait", 32'(dwait), 32'd1);
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        dREN = 1'b0;
        @(negedge CLK);
        check_val("s8_ramREN", 32'(ramREN), 32'd0);
        check_val("s8_ramWEN", 32'(ramWEN), 32'd0);
        check_val("s8_dwait", 32'(dwait), 32'd1);
        check_val("s8_ramaddr", ramaddr, 32'd0);

        repeat (3) @(negedge CLK);
        check_val("dq_left", 32'(dq.size()), 32'd0);
        check_val("iq_left", 32'(iq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
